// File: rtl/cascade_counter.sv
// Multi-stage synchronous up/down counter. Stage carries come from a same-cycle
// AND chain of terminal flags. Wrap or saturation applies at the full-width end value.
module cascade_counter #(
    parameter int STAGE_W = 8,
    parameter int STAGES  = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       up_dn,
    input  logic                       load,
    input  logic [STAGE_W*STAGES-1:0]  load_val,
    input  logic                       sat_mode,
    output logic [STAGE_W*STAGES-1:0]  count,
    output logic [STAGES-1:0]          stage_tc,
    output logic                       tc,
    output logic                       wrap
);

    localparam int N = STAGE_W * STAGES;

    logic [N-1:0]      count_reg;
    logic [N-1:0]      count_next;
    logic [N-1:0]      step_count;
    logic              wrap_reg;
    logic              wrap_next;
    logic [STAGES-1:0] carry;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [STAGE_W-1:0] cur;
            assign cur = count_reg[gi*STAGE_W +: STAGE_W];

            // The terminal value depends on the direction currently requested.
            assign stage_tc[gi] = up_dn ? (&cur) : ~(|cur);

            if (gi == 0) begin : g_first
                assign carry[gi] = en;
            end else begin : g_rest
                assign carry[gi] = carry[gi-1] & stage_tc[gi-1];
            end

            assign step_count[gi*STAGE_W +: STAGE_W] =
                !carry[gi] ? cur :
                (up_dn ? cur + STAGE_W'(1) : cur - STAGE_W'(1));
        end
    endgenerate

    assign tc = &stage_tc;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (en && !(tc && sat_mode)) begin
            // Every stage is terminal when tc is set, so the step rolls all stages together.
            count_next = step_count;
            wrap_next  = tc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign count = count_reg;
    assign wrap  = wrap_reg;

endmodule

// File: tb/tb_cascade_counter.sv
// Scoreboard bench for cascade_counter: a full-width arithmetic model queues the
// expected outputs. A negedge monitor pops each entry and compares it with the DUT.
module tb_cascade_counter;

    localparam int STAGE_W = 8;
    localparam int STAGES  = 3;
    localparam int N       = STAGE_W * STAGES;
    localparam logic [N-1:0] MAX_VAL = {N{1'b1}};

    logic              clk;
    logic              reset;
    logic              en;
    logic              up_dn;
    logic              load;
    logic [N-1:0]      load_val;
    logic              sat_mode;
    logic [N-1:0]      count;
    logic [STAGES-1:0] stage_tc;
    logic              tc;
    logic              wrap;

    typedef struct {
        logic [N-1:0]      count;
        logic              wrap;
        logic [STAGES-1:0] stage_tc;
        logic              tc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    logic [N-1:0] m_count;
    logic         m_wrap;

    cascade_counter #(.STAGE_W(STAGE_W), .STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .sat_mode (sat_mode),
        .count    (count),
        .stage_tc (stage_tc),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: apply the inputs, queue what the DUT must show this
    // cycle, then advance the model to the state after the coming edge.
    task automatic drive(input logic r, input logic ld, input logic [N-1:0] lv,
                         input logic e, input logic ud, input logic sm);
        exp_t         ex;
        logic         full_tc;
        logic [N-1:0] ones;
        @(posedge clk);
        #1;
        reset = r; load = ld; load_val = lv; en = e; up_dn = ud; sat_mode = sm;

        ones = MAX_VAL;
        full_tc = ud ? (m_count == ones) : (m_count == '0);
        ex.count = m_count;
        ex.wrap  = m_wrap;
        ex.tc    = full_tc;
        for (int k = 0; k < STAGES; k++) begin
            ex.stage_tc[k] = ud ? (m_count[k*STAGE_W +: STAGE_W] == {STAGE_W{1'b1}})
                                : (m_count[k*STAGE_W +: STAGE_W] == '0);
        end
        exp_q.push_back(ex);

        if (r) begin
            m_count = '0;
            m_wrap  = 1'b0;
        end else if (ld) begin
            m_count = lv;
            m_wrap  = 1'b0;
        end else if (e && full_tc && sm) begin
            m_wrap = 1'b0;
        end else if (e) begin
            m_count = ud ? m_count + 1 : m_count - 1;
            m_wrap  = full_tc;
        end else begin
            m_wrap = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t ex;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            txn++;
            $display("txn %0d: count=%h wrap=%b stage_tc=%b tc=%b", txn, count, wrap, stage_tc, tc);
            checks++;
            if (count !== ex.count) begin
                errors++;
                $display("FAIL count txn %0d: got %h expected %h", txn, count, ex.count);
            end
            checks++;
            if (wrap !== ex.wrap) begin
                errors++;
                $display("FAIL wrap txn %0d: got %b expected %b", txn, wrap, ex.wrap);
            end
            checks++;
            if (stage_tc !== ex.stage_tc) begin
                errors++;
                $display("FAIL stage_tc txn %0d: got %b expected %b", txn, stage_tc, ex.stage_tc);
            end
            checks++;
            if (tc !== ex.tc) begin
                errors++;
                $display("FAIL tc txn %0d: got %b expected %b", txn, tc, ex.tc);
            end
        end
    end

    initial begin
        logic [N-1:0] lv;
        logic         r_in;
        logic         ld_in;
        logic         ud_in;
        logic         sm_in;
        logic         e_in;
        reset = 1'b1; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
        m_count = '0;
        m_wrap  = 1'b0;

        // Reset overrides load and enable.
        drive(1, 1, 24'h123456, 1, 1, 0);
        drive(0, 1, 24'h123456, 1, 1, 0);
        // Carry from stage 0 into stage 1.
        drive(0, 1, 24'h0000FF, 0, 1, 0);
        drive(0, 0, '0, 1, 1, 0);
        drive(0, 0, '0, 0, 1, 0);
        // Upward wrap pulse.
        drive(0, 1, 24'hFFFFFF, 0, 1, 0);
        drive(0, 0, '0, 1, 1, 0);
        drive(0, 0, '0, 0, 1, 0);
        drive(0, 0, '0, 0, 1, 0);
        // Downward wrap, then saturation at zero.
        drive(0, 0, '0, 1, 0, 0);
        drive(0, 0, '0, 0, 0, 0);
        drive(0, 1, '0, 0, 0, 0);
        drive(0, 0, '0, 1, 0, 1);
        drive(0, 0, '0, 1, 0, 1);
        drive(0, 0, '0, 0, 0, 1);
        // Saturation at all-ones.
        drive(0, 1, 24'hFFFFFF, 0, 1, 1);
        drive(0, 0, '0, 1, 1, 1);
        drive(0, 0, '0, 0, 1, 1);
        // Direction change across a stage boundary.
        drive(0, 1, 24'h0100FF, 0, 1, 0);
        drive(0, 0, '0, 1, 1, 0);
        drive(0, 0, '0, 1, 0, 0);
        drive(0, 0, '0, 0, 0, 0);
        // Reset mid-count, then resume from zero.
        drive(0, 1, 24'h00ABCD, 1, 1, 0);
        drive(0, 0, '0, 1, 1, 0);
        drive(1, 0, '0, 1, 1, 0);
        drive(0, 0, '0, 1, 1, 0);
        drive(0, 0, '0, 1, 1, 0);
        drive(0, 0, '0, 0, 1, 0);

        // Random run with loads biased toward the end values so wraps happen often.
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(0, 5))
                0:       lv = '0;
                1:       lv = MAX_VAL;
                2:       lv = 24'hFFFFFE;
                3:       lv = 24'h000001;
                4:       lv = 24'h00FFFF;
                default: lv = N'($urandom);
            endcase
            r_in  = ($urandom_range(0, 99) == 0);
            ld_in = ($urandom_range(0, 19) == 0);
            e_in  = ($urandom_range(0, 9) < 8);
            ud_in = ($urandom_range(0, 7) == 0) ? ~up_dn : up_dn;
            sm_in = ($urandom_range(0, 15) == 0) ? ~sat_mode : sat_mode;
            drive(r_in, ld_in, lv, e_in, ud_in, sm_in);
        end
        drive(0, 0, '0, 0, up_dn, sat_mode);

        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cascade_counter.md
CASCADE_COUNTER -- requirements
Module: cascade_counter

Interface
REQ-001 SHALL have parameter STAGE_W, default 8, width in bits of one counter stage.
REQ-002 SHALL have parameter STAGES, default 3, number of cascaded stages; total width N = STAGE_W*STAGES.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  input  1  count enable for the least-significant stage.
REQ-006 SHALL have port up_dn  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-008 SHALL have port load_val  input  N  value written to count on load.
REQ-009 SHALL have port sat_mode  input  1  1 = saturate at the end value, 0 = wrap around.
REQ-010 SHALL have port count  output  N  registered count; stage k occupies bits [k*STAGE_W +: STAGE_W].
REQ-011 SHALL have port stage_tc  output  STAGES  combinational; bit k high when stage k is at its terminal value for the current up_dn.
REQ-012 SHALL have port tc  output  1  combinational; AND of all stage_tc bits.
REQ-013 SHALL have port wrap  output  1  registered one-cycle pulse marking a full-width wrap.

Function
REQ-014 The terminal value of a stage SHALL be all-ones when up_dn=1 and all-zeros when up_dn=0.
REQ-015 Stage 0 SHALL step when en=1; stage k>0 SHALL step only when en=1 and stage_tc[0..k-1] are all 1 (ripple-free carry chain, all stages evaluated in the same cycle).
REQ-016 A stage step SHALL be +1 or -1 modulo 2^STAGE_W, so a terminal stage rolls to the opposite end.
REQ-017 Update priority SHALL be: reset > load > saturation hold > count step > hold.
REQ-018 load=1 SHALL set count to load_val on the next edge, regardless of en, sat_mode and tc; wrap SHALL be 0 that cycle.
REQ-019 When sat_mode=1, en=1 and tc=1, count SHALL hold: all-ones when counting up, zero when counting down; wrap SHALL stay 0.
REQ-020 When sat_mode=0, en=1 and tc=1, count SHALL roll to zero (up) or all-ones (down), and wrap SHALL be 1 for exactly the following cycle.
REQ-021 en=0 with load=0 SHALL hold count; wrap SHALL be 0.
REQ-022 A change of up_dn SHALL take effect in the same cycle: stage_tc and tc are recomputed combinationally, and the next step uses the new direction.
REQ-023 Latency SHALL be one clock from en, load or reset to the updated count; there is no additional output register stage.
REQ-024 The design SHALL be legal for STAGES >= 1 and STAGE_W >= 1; STAGES=1 degenerates to a single up/down counter.

Reset
REQ-025 On a clk edge with reset=1, count SHALL become 0 and wrap SHALL become 0, overriding load and en.
REQ-026 Reset asserted mid-count SHALL take effect on the next edge; counting SHALL resume from 0 on the first edge after reset deasserts, given en=1.
REQ-027 stage_tc and tc SHALL follow count combinationally during and after reset (up_dn=0 with count=0 gives tc=1).

Verification (STAGE_W=8, STAGES=3)
REQ-028 Carry: load 0x0000FF, then up_dn=1, en=1 for 1 cycle -> count=0x000100; stage_tc=3'b001 before the step.
REQ-029 Wrap up: load 0xFFFFFF, sat_mode=0, en=1 -> count=0x000000 and wrap=1 for one cycle, then 0.
REQ-030 Wrap down and saturation: from 0x000000, up_dn=0, sat_mode=0 -> count=0xFFFFFF with wrap pulse; with sat_mode=1 from 0x000000 -> count stays 0x000000 and wrap=0.
REQ-031 Priority: reset=1, load=1, en=1 together -> count=0; load=1 with en=1 and load_val=0x123456 -> count=0x123456.
REQ-032 Direction change: at 0x0100FF with up_dn=1, step -> 0x010100; then up_dn=0, step -> 0x0100FF.
REQ-033 Random run of 10k cycles with random en, up_dn, load and sat_mode, checked against an N-bit reference model, including the wrap pulse timing.
